// File: rtl/ksa_shuffle_engine.sv
`timescale 1ns / 1ps
// RC4 key-scheduling engine: optional identity fill of S, then the full i/j/key
// shuffle over a single-port S-RAM, sequenced internally from one start pulse.
module ksa_shuffle_engine #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned KEY_LEN = 3,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      init_en,
  input  logic [KEY_LEN*ADDR_W-1:0] key,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [ADDR_W-1:0]         mem_wdata,
  output logic                      mem_wren,
  input  logic [ADDR_W-1:0]         mem_rdata
);

  localparam int unsigned KeyW  = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam int unsigned WaitW = $clog2(RD_LAT + 2);

  localparam logic [ADDR_W-1:0] LastIdx  = '1;
  localparam logic [KeyW-1:0]   LastKey  = KeyW'(KEY_LEN - 1);
  localparam logic [WaitW-1:0]  LastWait = WaitW'(RD_LAT);

  typedef enum logic [2:0] {
    StIdle,
    StInitWr,
    StRdSi,
    StCalcJ,
    StRdSj,
    StWrSi,
    StWrSj,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  i_q, i_d;
  logic [ADDR_W-1:0]  j_q, j_d;
  logic [KeyW-1:0]    k_q, k_d;
  logic [ADDR_W-1:0]  si_q, si_d;
  logic [ADDR_W-1:0]  sj_q, sj_d;
  logic [WaitW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0]  key_sel;

  // key[0] occupies the most significant slice of the packed key vector.
  always_comb begin
    key_sel = '0;
    for (int unsigned e = 0; e < KEY_LEN; e++) begin
      if (k_q == KeyW'(e)) begin
        key_sel = key[(KEY_LEN-1-e)*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      si_q     <= '0;
      sj_q     <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      si_q     <= si_d;
      sj_q     <= sj_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    si_d     = si_q;
    sj_d     = sj_q;
    rd_cnt_d = rd_cnt_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          i_d      = '0;
          j_d      = '0;
          k_d      = '0;
          rd_cnt_d = '0;
          state_d  = init_en ? StInitWr : StRdSi;
        end
      end
      StInitWr: begin
        // i wraps back to 0 on the last address, ready for the shuffle.
        i_d = i_q + 1'b1;
        if (i_q == LastIdx) begin
          state_d = StRdSi;
        end
      end
      StRdSi: begin
        if (rd_cnt_q == LastWait) begin
          si_d     = mem_rdata;
          rd_cnt_d = '0;
          state_d  = StCalcJ;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      StCalcJ: begin
        j_d     = j_q + si_q + key_sel;
        state_d = StRdSj;
      end
      StRdSj: begin
        if (rd_cnt_q == LastWait) begin
          sj_d     = mem_rdata;
          rd_cnt_d = '0;
          state_d  = StWrSi;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      StWrSi: begin
        state_d = StWrSj;
      end
      StWrSj: begin
        k_d = (k_q == LastKey) ? '0 : k_q + 1'b1;
        if (i_q == LastIdx) begin
          state_d = StDone;
        end else begin
          i_d     = i_q + 1'b1;
          state_d = StRdSi;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    case (state_q)
      StInitWr: begin
        mem_addr  = i_q;
        mem_wdata = i_q;
        mem_wren  = 1'b1;
      end
      StRdSi: begin
        mem_addr = i_q;
      end
      StRdSj: begin
        mem_addr = j_q;
      end
      // When i == j the two writes carry the same value, so the swap is a no-op.
      StWrSi: begin
        mem_addr  = i_q;
        mem_wdata = sj_q;
        mem_wren  = 1'b1;
      end
      StWrSj: begin
        mem_addr  = j_q;
        mem_wdata = si_q;
        mem_wren  = 1'b1;
      end
      default: begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ksa_shuffle_engine.sv
`timescale 1ns / 1ps
// Directed bench for ksa_shuffle_engine: three configurations, each with its own S-RAM
// model (A: 4 entries/lat 1, B: 256 entries/lat 1, C: 4 entries/lat 2).
module tb_ksa_shuffle_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   total = 0;
  int   bad   = 0;

  // Instance A
  logic       start_a, init_a, busy_a, done_a, wren_a;
  logic [1:0] key_a, addr_a, wdata_a, rd_a;
  logic [1:0] mem_a [4];
  logic [1:0] fill_a;

  // Instance B
  logic        start_b, init_b, busy_b, done_b, wren_b;
  logic [23:0] key_b;
  logic [7:0]  addr_b, wdata_b, rd_b;
  logic [7:0]  mem_b [256];
  logic [1:0]  fill_b;

  // Instance C
  logic       start_c, init_c, busy_c, done_c, wren_c;
  logic [1:0] key_c, addr_c, wdata_c, rd_c1, rd_c2;
  logic [1:0] mem_c [4];
  logic [1:0] fill_c;

  ksa_shuffle_engine #(.ADDR_W(2), .KEY_LEN(1), .RD_LAT(1)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .init_en(init_a), .key(key_a),
    .busy(busy_a), .done(done_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
    .mem_wren(wren_a), .mem_rdata(rd_a)
  );

  ksa_shuffle_engine #(.ADDR_W(8), .KEY_LEN(3), .RD_LAT(1)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .init_en(init_b), .key(key_b),
    .busy(busy_b), .done(done_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
    .mem_wren(wren_b), .mem_rdata(rd_b)
  );

  ksa_shuffle_engine #(.ADDR_W(2), .KEY_LEN(1), .RD_LAT(2)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .init_en(init_c), .key(key_c),
    .busy(busy_c), .done(done_c), .mem_addr(addr_c), .mem_wdata(wdata_c),
    .mem_wren(wren_c), .mem_rdata(rd_c2)
  );

  // fill: 1 = identity, 2 = reversed (so a missing init pass is visible)
  always @(posedge clk) begin
    if (fill_a == 2'd1) for (int a = 0; a < 4; a++) mem_a[a] <= 2'(a);
    else if (fill_a == 2'd2) for (int a = 0; a < 4; a++) mem_a[a] <= 2'(3 - a);
    else if (wren_a) mem_a[addr_a] <= wdata_a;
    rd_a <= mem_a[addr_a];
  end

  always @(posedge clk) begin
    if (fill_b == 2'd1) for (int a = 0; a < 256; a++) mem_b[a] <= 8'(a);
    else if (fill_b == 2'd2) for (int a = 0; a < 256; a++) mem_b[a] <= 8'(255 - a);
    else if (wren_b) mem_b[addr_b] <= wdata_b;
    rd_b <= mem_b[addr_b];
  end

  always @(posedge clk) begin
    if (fill_c == 2'd1) for (int a = 0; a < 4; a++) mem_c[a] <= 2'(a);
    else if (fill_c == 2'd2) for (int a = 0; a < 4; a++) mem_c[a] <= 2'(3 - a);
    else if (wren_c) mem_c[addr_c] <= wdata_c;
    rd_c1 <= mem_c[addr_c];
    rd_c2 <= rd_c1;
  end

  // Per-busy-cycle trace of the memory port (index = busy cycle, 1-based).
  int   tr_addr  [320];
  int   tr_wdata [320];
  logic tr_wren  [320];

  int         gold [256];
  int         gold_j [256];
  logic [7:0] kb [3] = '{8'h00, 8'h02, 8'h49};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic busy_of(input int w);
    case (w)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic done_of(input int w);
    case (w)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  task automatic set_fill(input int w, input logic [1:0] mode);
    @(negedge clk);
    case (w)
      0:       fill_a = mode;
      1:       fill_b = mode;
      default: fill_c = mode;
    endcase
    @(negedge clk);
    fill_a = 2'd0;
    fill_b = 2'd0;
    fill_c = 2'd0;
  endtask

  // Pulse start, then count busy cycles and done pulses; optionally hammer start while busy.
  task automatic run(input int w, input bit spam, input int limit,
                     output int bcyc, output int dcyc, output int dpos);
    bcyc = 0;
    dcyc = 0;
    dpos = 0;
    @(negedge clk);
    set_start(w, 1'b1);
    @(negedge clk);
    set_start(w, 1'b0);
    for (int t = 0; t < limit; t++) begin
      if (!busy_of(w)) break;
      bcyc++;
      if (done_of(w)) begin
        dcyc++;
        dpos = bcyc;
      end
      if (bcyc < 320) begin
        case (w)
          0:       begin tr_addr[bcyc] = int'(addr_a); tr_wdata[bcyc] = int'(wdata_a);
                         tr_wren[bcyc] = wren_a; end
          1:       begin tr_addr[bcyc] = int'(addr_b); tr_wdata[bcyc] = int'(wdata_b);
                         tr_wren[bcyc] = wren_b; end
          default: begin tr_addr[bcyc] = int'(addr_c); tr_wdata[bcyc] = int'(wdata_c);
                         tr_wren[bcyc] = wren_c; end
        endcase
      end
      set_start(w, spam && (t % 5 == 2));
      @(negedge clk);
    end
    set_start(w, 1'b0);
  endtask

  initial begin
    int b, d, p, jj, tmp;
    reset   = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    init_a  = 1'b0; init_b  = 1'b0; init_c  = 1'b0;
    key_a   = 2'd1; key_b   = 24'h000249; key_c = 2'd1;
    fill_a  = 2'd0; fill_b  = 2'd0; fill_c  = 2'd0;

    // Golden software KSA for the 256-entry configuration
    for (int i = 0; i < 256; i++) gold[i] = i;
    jj = 0;
    for (int i = 0; i < 256; i++) begin
      jj = (jj + gold[i] + int'(kb[i % 3])) % 256;
      gold_j[i] = jj;
      tmp = gold[i]; gold[i] = gold[jj]; gold[jj] = tmp;
    end

    // 1. Held in reset: start toggling must not wake the engine
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_wren", wren_a, 0);
      check("rst_addr", addr_a, 0);
      start_a = ~start_a;
    end
    @(negedge clk);
    start_a = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    init_a  = 1'b1;
    start_a = 1'b1;
    check("idle_before_edge", busy_a, 0);
    @(negedge clk);
    start_a = 1'b0;
    check("busy_next_cycle", busy_a, 1);
    for (int t = 0; t < 100; t++) begin
      if (!busy_a) break;
      @(negedge clk);
    end
    check("first_run_drained", busy_a, 0);

    // 2. N=4, key=1, with init pass over a reversed memory
    set_fill(0, 2'd2);
    key_a = 2'd1;
    run(0, 1'b0, 60, b, d, p);
    check("s2_busy_cycles", b, 33);
    check("s2_done_count", d, 1);
    check("s2_done_last", p, 33);
    for (int c = 1; c <= 4; c++) begin
      check("s2_init_wren", tr_wren[c], 1);
      check("s2_init_addr", tr_addr[c], c - 1);
      check("s2_init_wdata", tr_wdata[c], c - 1);
    end
    check("s2_wrsj_i0_addr", tr_addr[11], 1);
    check("s2_wrsj_i1_addr", tr_addr[18], 2);
    check("s2_s0", mem_a[0], 0);
    check("s2_s1", mem_a[1], 2);
    check("s2_s2", mem_a[2], 3);
    check("s2_s3", mem_a[3], 1);

    // 3. key=0: i=0 and i=1 are self-swaps
    set_fill(0, 2'd2);
    key_a = 2'd0;
    run(0, 1'b0, 60, b, d, p);
    check("s3_busy_cycles", b, 33);
    check("s3_wrsi_i0_addr", tr_addr[10], 0);
    check("s3_wrsi_i0_wdata", tr_wdata[10], 0);
    check("s3_wrsj_i0_addr", tr_addr[11], 0);
    check("s3_wrsj_i1_addr", tr_addr[18], 1);
    check("s3_s0", mem_a[0], 0);
    check("s3_s1", mem_a[1], 2);
    check("s3_s2", mem_a[2], 3);
    check("s3_s3", mem_a[3], 1);

    // 4. Full-size KSA against the software model
    set_fill(1, 2'd2);
    init_b = 1'b1;
    run(1, 1'b0, 2100, b, d, p);
    check("s4_busy_cycles", b, 2049);
    check("s4_done_count", d, 1);
    check("s4_done_last", p, 2049);
    for (int i = 0; i < 6; i++) check("s4_j_trace", tr_addr[256 + 7 * (i + 1)], gold_j[i]);
    for (int a = 0; a < 256; a++) check("s4_sbox", mem_b[a], gold[a]);

    // 5. Read latency 2, no init pass, memory preloaded to identity
    set_fill(2, 2'd1);
    init_c = 1'b0;
    key_c  = 2'd1;
    run(2, 1'b0, 60, b, d, p);
    check("s5_busy_cycles", b, 37);
    check("s5_done_last", p, 37);
    for (int c = 1; c <= 3; c++) begin
      check("s5_rdsi_addr", tr_addr[c], 0);
      check("s5_rdsi_wren", tr_wren[c], 0);
      check("s5_rdsj_addr", tr_addr[c + 4], 1);
    end
    check("s5_wrsi_wdata", tr_wdata[8], 1);
    check("s5_wrsj_wdata", tr_wdata[9], 0);
    check("s5_s0", mem_c[0], 0);
    check("s5_s1", mem_c[1], 2);
    check("s5_s2", mem_c[2], 3);
    check("s5_s3", mem_c[3], 1);

    // 6. Abort during WR_SI of i=1, then a clean restart with start spam
    set_fill(0, 2'd2);
    key_a  = 2'd1;
    init_a = 1'b1;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int c = 0; c < 16; c++) @(negedge clk);
    check("s6_wrsi_wren", wren_a, 1);
    check("s6_wrsi_addr", addr_a, 1);
    check("s6_wrsi_wdata", wdata_a, 2);
    #1 reset = 1'b0;
    #1;
    check("s6_abort_busy", busy_a, 0);
    check("s6_abort_wren", wren_a, 0);
    check("s6_abort_done", done_a, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("s6_idle_after", busy_a, 0);
    run(0, 1'b1, 60, b, d, p);
    check("s6_busy_cycles", b, 33);
    check("s6_done_count", d, 1);
    check("s6_s0", mem_a[0], 0);
    check("s6_s1", mem_a[1], 2);
    check("s6_s2", mem_a[2], 3);
    check("s6_s3", mem_a[3], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ksa_shuffle_engine.md
Name: ksa_shuffle_engine

Overview:
Parametrised RC4 key-scheduling (KSA) engine that runs the whole KSA without outside sequencing. It owns the i, j and key-index counters and drives a single-port working-memory (S) interface directly. An optional identity-fill pass (S[i]=i) runs before the shuffle. It sits between the top-level control FSM (start/done handshake) and the S-RAM, and replaces per-step external sequencing with one start pulse that produces a fully shuffled S array.

Parameters:
ADDR_W, 8, S depth N = 2^ADDR_W; S data width and key element width are also ADDR_W
KEY_LEN, 3, number of key elements; legal range 1..N
RD_LAT, 1, S-RAM read latency in cycles from address to valid mem_rdata; must be at least 1

Ports:
clk  in  1  clock, all state changes on the rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  sampled only in IDLE; one-cycle pulse or level
init_en  in  1  sampled with start; 1 = run the identity-fill pass before the shuffle
key  in  KEY_LEN*ADDR_W  key[0] is the most significant element; must stay stable while busy
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at completion
mem_addr  out  ADDR_W  S-RAM address
mem_wdata  out  ADDR_W  S-RAM write data
mem_wren  out  1  S-RAM write enable
mem_rdata  in  ADDR_W  S-RAM read data

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; i, j, k, si, sj registers=0; busy=0, done=0, mem_wren=0, mem_addr=0, mem_wdata=0.
- Reset asserted mid-run: abort immediately. S contents are then undefined (partially shuffled); no done pulse is produced.
- States: IDLE, INIT_WR, RD_SI, CALC_J, RD_SJ, WR_SI, WR_SJ, DONE.
- IDLE: on start=1 clear i, j, k; go to INIT_WR if init_en=1, else RD_SI. start is ignored in every other state.
- INIT_WR: mem_addr=i, mem_wdata=i, mem_wren=1, one cycle per address. i increments each cycle; when i=N-1, i wraps to 0 and the state goes to RD_SI. The pass takes N cycles.
- RD_SI: mem_addr=i for RD_LAT+1 cycles (internal wait counter). mem_rdata is captured into si at the end of the last cycle.
- CALC_J (1 cycle): j <= (j + si + key[k]) mod N; all arithmetic is ADDR_W-bit wrap-around.
- RD_SJ: mem_addr=j for RD_LAT+1 cycles; mem_rdata is captured into sj.
- WR_SI (1 cycle): mem_addr=i, mem_wdata=sj, mem_wren=1.
- WR_SJ (1 cycle): mem_addr=j, mem_wdata=si, mem_wren=1.
  - Same edge: k <= (k==KEY_LEN-1) ? 0 : k+1. No divider is used.
  - If i=N-1, go to DONE; otherwise i <= i+1 and go to RD_SI.
- i==j: both writes happen with the same value, which is a correct no-op swap and needs no special case.
- DONE (1 cycle): done=1, busy=1, then IDLE.
- mem_wren is high only in INIT_WR, WR_SI and WR_SJ. mem_addr and mem_wdata are don't-care whenever mem_wren=0 outside the read states, but must be driven.
- Shuffle cost per i: 2*(RD_LAT+1)+3 cycles (7 at RD_LAT=1).
- Total busy cycles: (init_en ? N : 0) + N*(2*RD_LAT+5) + 1.

Test Plan:
1. Reset/idle: ADDR_W=2, RD_LAT=1. Hold reset=0 while toggling start -> busy=0, done=0, mem_wren=0 throughout. After release, the first start pulse raises busy on the following cycle.
2. Shuffle: ADDR_W=2, KEY_LEN=1, key=1, init_en=1, start pulse -> INIT writes S=[0,1,2,3]. Final S=[0,2,3,1]. busy high exactly 33 cycles; done high one cycle on the last busy cycle.
3. Self-swap: ADDR_W=2, KEY_LEN=1, key=0, init_en=1 -> i=0 and i=1 give j=i with writes of an unchanged value. Final S=[0,2,3,1].
4. Full size: ADDR_W=8, KEY_LEN=3, key=24'h000249, init_en=1.
   - Final 256-entry S matches the golden software KSA.
   - k sequence is 0,1,2,0,...
   - busy duration 256+1792+1 = 2049 cycles.
5. Latency and mode: RD_LAT=2, init_en=0 with memory preloaded to identity, start -> same final S as scenario 2 (ADDR_W=2, key=1). Each read state holds its address for 3 cycles; busy duration 4*9+1 = 37 cycles.
6. Abort and robustness:
   - Assert reset during WR_SI of i=1 -> busy/mem_wren drop asynchronously.
   - Restart with init_en=1 -> the correct result from scenario 2.
   - start pulses while busy have no effect.
